// File: rtl/arbitro_sumador.sv
// arbitro_sumador: four requesters share one WORD-bit ripple adder.
// A winner's operands are latched at grant, the sum is registered one
// cycle later and held with valid until the consumer acks.
// Build option: define ARB_SUMADOR_RR_EN for round-robin arbitration;
// otherwise fixed priority (lowest index wins) with no pointer register.

// Sumador: plain WORD-bit ripple-carry adder.
module sumador #(
    parameter int WORD = 32
) (
    input  logic [WORD-1:0] i_a,
    input  logic [WORD-1:0] i_b,
    input  logic            i_ci,
    output logic [WORD-1:0] o_s,
    output logic            o_co
);
    logic w_c;

    // Carry ripples from bit 0 upward.
    always_comb begin
        o_s = '0;
        w_c = i_ci;
        for (int k = 0; k < WORD; k++) begin
            o_s[k] = i_a[k] ^ i_b[k] ^ w_c;
            w_c    = (i_a[k] & i_b[k]) | (w_c & (i_a[k] ^ i_b[k]));
        end
        o_co = w_c;
    end
endmodule

module arbitro_sumador #(
    parameter int WORD = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [4*WORD-1:0] opea,
    input  logic [4*WORD-1:0] opeb,
    input  logic [3:0]        cin,
    output logic [3:0]        gnt,
    output logic [WORD-1:0]   sal,
    output logic              cout,
    output logic [1:0]        id,
    output logic              valid,
    input  logic              ack
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_grant;
    logic              w_load;
    logic              w_done;
    logic [1:0]        w_win;
    logic [WORD-1:0]   r_opa;
    logic [WORD-1:0]   r_opb;
    logic              r_ci;
    logic [1:0]        r_idx;
    logic [3:0]        r_gnt;
    logic [WORD-1:0]   r_sal;
    logic              r_cout;
    logic [1:0]        r_id;
    logic              r_valid;
    logic [WORD-1:0]   w_sum;
    logic              w_co;

`ifdef ARB_SUMADOR_RR_EN
    logic [1:0] r_ptr;
    logic [1:0] w_cand;

    // Round-robin: scan downward so the slot right after r_ptr is assigned last and wins.
    always_comb begin
        w_win  = r_ptr + 2'd1;
        w_cand = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            w_cand = r_ptr + 2'(k);
            if (req[w_cand]) w_win = w_cand;
        end
    end

    // Pointer remembers the last served requester once its result is consumed.
    always_ff @(posedge clk) begin
        if (rst) r_ptr <= 2'd3;
        else if (w_done) r_ptr <= r_idx;
    end
`else
    // Fixed priority: lowest requesting index wins.
    always_comb begin
        w_win = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req[k]) w_win = 2'(k);
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    // Next state and per-state strobes; ack only matters in RESP, req only in IDLE.
    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_load  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (req != 4'd0) begin
                    w_grant = 1'b1;
                    w_next  = CALC;
                end
            end
            CALC: begin
                w_load = 1'b1;
                w_next = RESP;
            end
            RESP: begin
                if (ack) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Latch the winner's operands; the adder only ever sees these registers.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_opa <= opea[int'(w_win)*WORD +: WORD];
            r_opb <= opeb[int'(w_win)*WORD +: WORD];
            r_ci  <= cin[w_win];
            r_idx <= w_win;
        end
    end

    sumador #(.WORD(WORD)) u_sumador (
        .i_a  (r_opa),
        .i_b  (r_opb),
        .i_ci (r_ci),
        .o_s  (w_sum),
        .o_co (w_co)
    );

    // Grant pulse and result valid handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt   <= 4'd0;
            r_valid <= 1'b0;
        end else begin
            r_gnt <= w_grant ? (4'd1 << w_win) : 4'd0;
            if (w_load) r_valid <= 1'b1;
            else if (w_done) r_valid <= 1'b0;
        end
    end

    // Result registers, captured in CALC and held through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sal  <= '0;
            r_cout <= 1'b0;
            r_id   <= 2'd0;
        end else if (w_load) begin
            r_sal  <= w_sum;
            r_cout <= w_co;
            r_id   <= r_idx;
        end
    end

    assign gnt   = r_gnt;
    assign sal   = r_sal;
    assign cout  = r_cout;
    assign id    = r_id;
    assign valid = r_valid;
endmodule

// File: tb/tb_arbitro_sumador.sv
// Scoreboard bench for arbitro_sumador: a reference model predicts grants
// and sums from the arbitration and latency rules; a monitor compares.
module tb_arbitro_sumador;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     req = 4'd0;
    logic [4*W-1:0] opea = '0;
    logic [4*W-1:0] opeb = '0;
    logic [3:0]     cin = 4'd0;
    logic           ack = 1'b0;
    logic [3:0]     gnt;
    logic [W-1:0]   sal;
    logic           cout;
    logic [1:0]     id;
    logic           valid;

    arbitro_sumador #(.WORD(W)) dut (
        .clk(clk), .rst(rst), .req(req), .opea(opea), .opeb(opeb), .cin(cin),
        .gnt(gnt), .sal(sal), .cout(cout), .id(id), .valid(valid), .ack(ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic [1:0]   i;
    } res_t;

    res_t sb[$];
    int   glog[$];
    int   n_vec = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    // Reference model state
    int         m_phase = 0;   // 0 waiting, 1 computing, 2 result offered
    int         m_last = 3;
    int         m_win = 0;
    logic [3:0] exp_gnt = 4'd0;
    logic       exp_valid = 1'b0;

    function automatic int pick(logic [3:0] r, int last);
`ifdef ARB_SUMADOR_RR_EN
        for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
`else
        for (int k = 0; k < 4; k++) if (r[k]) return k;
`endif
        return 0;
    endfunction

    function automatic int oh2i(logic [3:0] g);
        for (int k = 0; k < 4; k++) if (g[k]) return k;
        return -1;
    endfunction

    // Model: reacts to the same inputs the DUT samples at each rising edge.
    always @(posedge clk) begin
        logic [W:0] full;
        res_t r;
        if (rst) begin
            m_phase = 0; m_last = 3; exp_gnt = 4'd0; exp_valid = 1'b0;
            sb.delete();
        end else if (m_phase == 0) begin
            if (req != 4'd0) begin
                m_win = pick(req, m_last);
                full = {1'b0, opea[m_win*W +: W]} + {1'b0, opeb[m_win*W +: W]} + (W+1)'(cin[m_win]);
                r.s = full[W-1:0]; r.c = full[W]; r.i = 2'(m_win);
                sb.push_back(r);
                exp_gnt = 4'd1 << m_win;
                m_phase = 1;
            end else exp_gnt = 4'd0;
        end else if (m_phase == 1) begin
            exp_gnt = 4'd0; exp_valid = 1'b1; m_phase = 2;
        end else begin
            if (ack) begin
                exp_valid = 1'b0; m_phase = 0;
`ifdef ARB_SUMADOR_RR_EN
                m_last = m_win;
`endif
            end
        end
    end

    // Monitor: sample mid-cycle, pop an expected result on each new valid.
    res_t hold;
    bit   have_hold = 1'b0;
    bit   prev_valid = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            n_vec++;
            if (gnt !== exp_gnt) begin
                n_fail++; $display("FAIL gnt: got %b want %b at %0t", gnt, exp_gnt, $time);
            end
            n_vec++;
            if (valid !== exp_valid) begin
                n_fail++; $display("FAIL valid: got %b want %b at %0t", valid, exp_valid, $time);
            end
            if (gnt != 4'd0) glog.push_back(oh2i(gnt));
            if (valid === 1'b1) begin
                if (!prev_valid) begin
                    n_vec++;
                    if (sb.size() == 0) begin
                        n_fail++; have_hold = 1'b0;
                        $display("FAIL result: got unexpected id=%0d want none queued", id);
                    end else begin
                        hold = sb.pop_front(); have_hold = 1'b1;
                    end
                end
                if (have_hold) begin
                    n_vec++;
                    if (sal !== hold.s || cout !== hold.c || id !== hold.i) begin
                        n_fail++;
                        $display("FAIL result: got sal=%h cout=%b id=%0d want sal=%h cout=%b id=%0d",
                                 sal, cout, id, hold.s, hold.c, hold.i);
                    end
                end
            end
            prev_valid = (valid === 1'b1);
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(string name, logic [W+7:0] got, logic [W+7:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++; $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_zero(string name);
        chk({name, " sal"}, (W+8)'(sal), '0);
        chk({name, " cout"}, (W+8)'(cout), '0);
        chk({name, " id"}, (W+8)'(id), '0);
        chk({name, " valid"}, (W+8)'(valid), '0);
        chk({name, " gnt"}, (W+8)'(gnt), '0);
    endtask

    task automatic set_op(int k, logic [W-1:0] a, logic [W-1:0] b, logic c);
        opea[k*W +: W] = a; opeb[k*W +: W] = b; cin[k] = c;
    endtask

    // Drain: ack until valid is low, bounded.
    task automatic drain(string name);
        int t = 0;
        ack = 1'b1;
        tick();
        while (valid !== 1'b0 && t < 20) begin tick(); t++; end
        n_vec++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL %s drain: got valid=%b want 0", name, valid); end
        ack = 1'b0;
    endtask

    initial begin
        int exp_order[$];
        int t;
        rst = 1'b1;
        tick(2);
        check_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        // Single request 5 + 3
        set_op(0, 32'h5, 32'h3, 1'b0); set_op(1, 32'h1234, 32'h1, 1'b1);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        chk("single sal", (W+8)'(sal), (W+8)'(32'h8));
        chk("single cout", (W+8)'(cout), '0);
        chk("single id", (W+8)'(id), '0);
        tick(3);
        drain("single");

        // Overflow on requester 2
        set_op(2, 32'hFFFF_FFFF, 32'h0, 1'b1);
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        chk("ovf sal", (W+8)'(sal), '0);
        chk("ovf cout", (W+8)'(cout), (W+8)'(1));
        chk("ovf id", (W+8)'(id), (W+8)'(2));
        drain("ovf");

        // Backpressure: changing requests while the result waits
        set_op(3, $urandom, $urandom, 1'b1);
        req = 4'b1000;
        tick(2);
        for (int k = 0; k < 10; k++) begin
            req = 4'($urandom_range(1, 15));
            for (int j = 0; j < 4; j++) set_op(j, $urandom, $urandom, 1'($urandom));
            tick();
        end
        req = 4'b0000;
        drain("backpressure");

        // Stray ack in IDLE and CALC
        ack = 1'b1;
        tick(2);
        set_op(1, $urandom, $urandom, 1'b0);
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        ack = 1'b0;
        tick(2);
        drain("stray ack");

        // Reset during CALC
        req = 4'b1111;
        tick();
        rst = 1'b1; req = 4'b0000;
        tick();
        check_zero("rst calc");
        rst = 1'b0;

        // Reset during RESP
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        rst = 1'b1;
        tick();
        check_zero("rst resp");
        glog.delete();
        rst = 1'b0;

        // Contention with all requesters active, ack whenever valid
`ifdef ARB_SUMADOR_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0};
`endif
        req = 4'b1111; ack = 1'b1;
        t = 0;
        while (glog.size() < exp_order.size() && t < 60) begin tick(); t++; end
        n_vec++;
        if (glog.size() < exp_order.size()) begin
            n_fail++; $display("FAIL contention: got %0d grants want %0d", glog.size(), exp_order.size());
        end else begin
            for (int k = 0; k < exp_order.size(); k++)
                chk($sformatf("grant order[%0d]", k), (W+8)'(glog[k]), (W+8)'(exp_order[k]));
        end
        req = 4'b0000;
        drain("contention");

        // Randomized traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            req = ($urandom_range(0, 9) < 3) ? 4'd0 : 4'($urandom_range(1, 15));
            for (int j = 0; j < 4; j++) begin
                case ($urandom_range(0, 3))
                    0: set_op(j, '1, $urandom_range(0, 1), 1'($urandom));
                    default: set_op(j, $urandom, $urandom, 1'($urandom));
                endcase
            end
            ack = 1'($urandom);
            tick();
        end
        rst = 1'b0; req = 4'b0000;
        drain("final");
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/arbitro_sumador.md
ARBITRO_SUMADOR -- requirements
Module: arbitro_sumador

Interface
REQ-001 SHALL have parameter WORD, default 32, operand and result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req  input  4  per-requester request; bit k belongs to requester k.
REQ-005 SHALL have port opea  input  4*WORD  operand a; requester k at bits [k*WORD +: WORD].
REQ-006 SHALL have port opeb  input  4*WORD  operand b; same packing as opea.
REQ-007 SHALL have port cin  input  4  carry-in; bit k belongs to requester k.
REQ-008 SHALL have port gnt  output  4  one-hot grant pulse.
REQ-009 SHALL have port sal  output  WORD  registered sum.
REQ-010 SHALL have port cout  output  1  registered carry-out.
REQ-011 SHALL have port id  output  2  index of the requester owning sal/cout.
REQ-012 SHALL have port valid  output  1  result valid.
REQ-013 SHALL have port ack  input  1  consumer accepts result.

Function
REQ-014 SHALL share one instance of the team's WORD-bit Sumador ripple adder between four requesters, fed only from internal operand registers.
REQ-015 SHALL implement FSM states IDLE, CALC, RESP.
REQ-016 In IDLE, at an edge where req != 0: SHALL select a winner, latch its opea/opeb/cin and index, set gnt to the winner's one-hot value for exactly one cycle, and go to CALC.
REQ-017 In IDLE with req == 0: SHALL remain in IDLE, gnt = 0.
REQ-018 In CALC: SHALL register the adder's sal/cout, drive id with the latched index, set valid = 1, and go to RESP (one cycle in CALC, unconditionally).
REQ-019 In RESP: SHALL hold sal, cout, id and valid stable until an edge with ack = 1.
REQ-020 At that edge, SHALL clear valid, update the priority state, and go to IDLE.
REQ-021 Latency: req sampled at edge N gives gnt high N..N+1 and valid high from edge N+1; earliest next grant is at edge N+3.
REQ-022 ack SHALL be ignored outside RESP.
REQ-023 req and operand changes outside IDLE SHALL be ignored.
REQ-024 A requester holding req after its gnt pulse SHALL be treated as a new request.
REQ-025 Sum SHALL be modulo 2^WORD, with cout the carry out of bit WORD-1.
REQ-026 Example: all-ones + 0 + cin=1 gives sal=0, cout=1.
REQ-027 gnt SHALL never have more than one bit set.
REQ-028 valid SHALL be 1 only in RESP.

Reset
REQ-029 With rst = 1 at an edge, in any state, SHALL force state=IDLE, gnt=0, valid=0, sal=0, cout=0, id=0, and last-granted pointer=3.
REQ-030 Reset mid-CALC or mid-RESP SHALL discard the pending result; no valid pulse SHALL follow.
REQ-031 rst SHALL take precedence over req and ack at the same edge.

Configuration
REQ-032 Macro ARB_SUMADOR_RR_EN defined: SHALL arbitrate round-robin.
REQ-033 Round-robin search SHALL start at (last-granted + 1) mod 4; the pointer SHALL update to the winner on ack completion.
REQ-034 Macro ARB_SUMADOR_RR_EN undefined: SHALL use fixed priority, lowest index wins, and no pointer register shall be present.
REQ-035 Both modes SHALL have identical latency and handshake behaviour.

Verification
REQ-036 Single request, WORD=32: req=0001, opea0=0x0000_0005, opeb0=0x0000_0003, cin0=0 -> gnt=0001 for one cycle, next cycle valid=1, sal=0x8, cout=0, id=0; valid held until ack.
REQ-037 Overflow: req=0100, opea2=0xFFFF_FFFF, opeb2=0, cin2=1 -> sal=0, cout=1, id=2.
REQ-038 Contention with RR_EN, req=1111 held continuously and ack=1 whenever valid -> grant order 0,1,2,3,0; without macro -> 0,0,0.
REQ-039 Backpressure: hold ack=0 for 10 cycles after valid -> sal/id/valid unchanged, gnt=0, new req ignored; ack=1 -> valid=0 next cycle.
REQ-040 Reset mid-operation: assert rst in CALC, and again in RESP -> next cycle valid=0, gnt=0, sal=0; first post-reset grant with req=1111 goes to requester 0.
REQ-041 Stray ack: ack=1 in IDLE and CALC -> no state change; result from CALC still reaches RESP with valid=1.
